des_job_controller: RTL and testbench

- Host-side driver for one des_block instance (the LFSR/DES/mask-parity counting block).
- Accepts a job descriptor over a valid/ready handshake and holds it in registers.
- Starts the block, waits for `done`, and returns the 64-bit counter with the job ID over a second valid/ready handshake.
- Pulses `restart_block` so the block is clean for the next job. Sits between the job dispatcher/host interface and the des_block array.

---
 rtl/des_job_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_des_job_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_job_controller.sv
// ---------------------------------------------------------------------------
// des_job_controller
//
// Host-side driver for a single des_block. A job descriptor is accepted on
// the job_* valid/ready handshake and registered onto the blk_* config
// outputs. The controller then pulses blk_start, waits for blk_done, and
// returns the captured blk_counter with the job tag on the res_*
// valid/ready handshake. Finally it pulses blk_restart so the block is
// clean for the next job.
//
// State sequence: IDLE -> LOAD -> RUN -> REPORT -> CLEAR -> IDLE.
// abort in LOAD or RUN skips straight to CLEAR and produces no result.
//
// Optional build macro: WATCHDOG_EN
//   Defined   : a run counter bounds the RUN phase to blk_limit + WDOG_SLACK
//               cycles. On expiry a result is reported with res_timeout=1.
//   Undefined : no run counter; res_timeout is tied to 0.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   job_valid/job_ready job descriptor handshake
//   job_id              job tag (JOB_ID_W bits)
//   job_seed/poly       LFSR seed and polynomial
//   job_mask_i/o        input and output masks
//   job_limit           message count limit
//   job_keys            768-bit concatenated round keys
//   abort               cancel the job in LOAD or RUN
//   blk_start           one-cycle start pulse to des_block
//   blk_restart         one-cycle restart_block pulse to des_block
//   blk_seed..blk_keys  registered config driven to des_block
//   blk_counter         des_block message counter
//   blk_done            des_block completion flag
//   res_valid/res_ready result handshake
//   res_id, res_count   tag and captured counter of the completed job
//   res_timeout         result came from the watchdog
//   busy                controller is not in IDLE
//   jobs_done           number of results handed off (wraps at 2^32)
// ---------------------------------------------------------------------------
module des_job_controller #(
    parameter int          JOB_ID_W   = 8,
    parameter logic [63:0] WDOG_SLACK = 64'd64
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                job_valid,
    output logic                job_ready,
    input  logic [JOB_ID_W-1:0] job_id,
    input  logic [63:0]         job_seed,
    input  logic [63:0]         job_poly,
    input  logic [63:0]         job_mask_i,
    input  logic [63:0]         job_mask_o,
    input  logic [63:0]         job_limit,
    input  logic [767:0]        job_keys,
    input  logic                abort,

    output logic                blk_start,
    output logic                blk_restart,
    output logic [63:0]         blk_seed,
    output logic [63:0]         blk_poly,
    output logic [63:0]         blk_mask_i,
    output logic [63:0]         blk_mask_o,
    output logic [63:0]         blk_limit,
    output logic [767:0]        blk_keys,
    input  logic [63:0]         blk_counter,
    input  logic                blk_done,

    output logic                res_valid,
    input  logic                res_ready,
    output logic [JOB_ID_W-1:0] res_id,
    output logic [63:0]         res_count,
    output logic                res_timeout,

    output logic                busy,
    output logic [31:0]         jobs_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_REPORT,
        S_CLEAR
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [JOB_ID_W-1:0]   id_q;
    logic                  accept;     // job handshake this cycle
    logic                  capture;    // result is captured at this edge
    logic                  report_ack; // result handshake this cycle

`ifdef WATCHDOG_EN
    logic [63:0] run_cnt;
    logic [63:0] run_cnt_next;
    logic [63:0] wdog_limit;
    logic        wdog_hit;
    logic        capture_to;           // capture caused by the watchdog

    assign run_cnt_next = run_cnt + 64'd1;
    assign wdog_limit   = blk_limit + WDOG_SLACK;
    // Fires on the RUN edge at which the counter would reach the limit,
    // so a limit of L yields the result after exactly L RUN cycles.
    assign wdog_hit     = (run_cnt_next == wdog_limit);
`endif

    assign accept     = (state_q == S_IDLE) && job_valid;
    assign report_ack = (state_q == S_REPORT) && res_ready;
    assign busy       = (state_q != S_IDLE);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only (synchronous), so it
        // lives inside the clocked branch rather than in the sensitivity list.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and Moore/Mealy controls
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case statement can infer a latch.
        state_d     = state_q;
        job_ready   = 1'b0;
        blk_start   = 1'b0;
        blk_restart = 1'b0;
        capture     = 1'b0;
`ifdef WATCHDOG_EN
        capture_to  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) state_d = S_LOAD;
            end
            S_LOAD: begin
                blk_start = 1'b1;
                state_d   = abort ? S_CLEAR : S_RUN;
            end
            S_RUN: begin
                // Priority: abort > blk_done > watchdog.
                if (abort) begin
                    state_d = S_CLEAR;
                end else if (blk_done) begin
                    capture = 1'b1;
                    state_d = S_REPORT;
`ifdef WATCHDOG_EN
                end else if (wdog_hit) begin
                    capture    = 1'b1;
                    capture_to = 1'b1;
                    state_d    = S_REPORT;
`endif
                end
            end
            S_REPORT: begin
                // abort is deliberately not looked at here: the result exists.
                if (res_ready) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                blk_restart = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Config, result and statistics registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples the pre-edge values of its peers.
        if (!rst_n) begin
            blk_seed   <= '0;
            blk_poly   <= '0;
            blk_mask_i <= '0;
            blk_mask_o <= '0;
            blk_limit  <= '0;
            blk_keys   <= '0;
            id_q       <= '0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_count  <= '0;
            jobs_done  <= '0;
        end else begin
            // Config only moves on the job handshake; des_block sees stable
            // values for the whole job.
            if (accept) begin
                blk_seed   <= job_seed;
                blk_poly   <= job_poly;
                blk_mask_i <= job_mask_i;
                blk_mask_o <= job_mask_o;
                blk_limit  <= job_limit;
                blk_keys   <= job_keys;
                id_q       <= job_id;
            end
            if (capture) begin
                res_valid <= 1'b1;
                res_id    <= id_q;
                res_count <= blk_counter;
            end else if (report_ack) begin
                res_valid <= 1'b0;
                jobs_done <= jobs_done + 32'd1;
            end
        end
    end

`ifdef WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt     <= '0;
            res_timeout <= 1'b0;
        end else begin
            if (accept) begin
                run_cnt <= '0;
            end else if (state_q == S_RUN) begin
                run_cnt <= run_cnt_next;
            end
            if (capture) begin
                res_timeout <= capture_to;
            end else if (report_ack) begin
                res_timeout <= 1'b0;
            end
        end
    end
`else
    assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_des_job_controller.sv
// ---------------------------------------------------------------------------
// tb_des_job_controller
//
// Self-checking bench for des_job_controller. The bench plays the des_block
// role itself: it raises blk_done a chosen number of cycles after blk_start
// with a chosen counter value, and predicts every result from the job it
// issued. Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_des_job_controller;

    localparam int          IW    = 8;
    localparam logic [63:0] SLACK = 64'd64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [IW-1:0] job_id = '0;
    logic [63:0]   job_seed = '0, job_poly = '0, job_mask_i = '0, job_mask_o = '0, job_limit = '0;
    logic [767:0]  job_keys = '0;
    logic          abort = 1'b0;
    logic          blk_start, blk_restart;
    logic [63:0]   blk_seed, blk_poly, blk_mask_i, blk_mask_o, blk_limit;
    logic [767:0]  blk_keys;
    logic [63:0]   blk_counter = '0;
    logic          blk_done = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [IW-1:0] res_id;
    logic [63:0]   res_count;
    logic          res_timeout;
    logic          busy;
    logic [31:0]   jobs_done;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_jobs = '0;

    int start_cnt = 0;
    int restart_cnt = 0;
    int overlap_cnt = 0;

    // Expected config of the job in flight.
    logic [63:0]  cur_seed, cur_poly, cur_mi, cur_mo, cur_limit;
    logic [767:0] cur_keys;

    always #5 clk = ~clk;

    des_job_controller #(.JOB_ID_W(IW), .WDOG_SLACK(SLACK)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
        .job_seed(job_seed), .job_poly(job_poly), .job_mask_i(job_mask_i),
        .job_mask_o(job_mask_o), .job_limit(job_limit), .job_keys(job_keys),
        .abort(abort),
        .blk_start(blk_start), .blk_restart(blk_restart),
        .blk_seed(blk_seed), .blk_poly(blk_poly), .blk_mask_i(blk_mask_i),
        .blk_mask_o(blk_mask_o), .blk_limit(blk_limit), .blk_keys(blk_keys),
        .blk_counter(blk_counter), .blk_done(blk_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .res_timeout(res_timeout),
        .busy(busy), .jobs_done(jobs_done)
    );

    // Pulse bookkeeping, one sample per cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (blk_start) start_cnt++;
            if (blk_restart) restart_cnt++;
            if (blk_start && blk_restart) overlap_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, got running want done");
        $fatal(1, "global timeout");
    end

    // Issue one job and check the LOAD cycle. Returns at the LOAD negedge.
    task automatic send_job(input logic [IW-1:0] id, input logic [63:0] limit, input string tag);
        int n;
        n = 0;
        cur_seed  = {$urandom, $urandom};
        cur_poly  = {$urandom, $urandom};
        cur_mi    = {$urandom, $urandom};
        cur_mo    = {$urandom, $urandom};
        cur_limit = limit;
        for (int i = 0; i < 24; i++) cur_keys[i*32 +: 32] = $urandom;
        while (!job_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!job_ready) begin
            errors++;
            $display("FAIL %s_wait_ready: got job_ready=0 want 1 within 50 cycles", tag);
        end
        job_valid = 1'b1; job_id = id; job_seed = cur_seed; job_poly = cur_poly;
        job_mask_i = cur_mi; job_mask_o = cur_mo; job_limit = cur_limit; job_keys = cur_keys;
        @(negedge clk);
        // Scramble the job bus: config must only move on the handshake.
        job_valid = 1'b0; job_id = IW'($urandom);
        job_seed = {$urandom, $urandom}; job_limit = {$urandom, $urandom};
        job_keys = {24{$urandom}};
        checks++;
        if (blk_start !== 1'b1 || job_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_load: got start/ready/busy=%b%b%b want 101", tag, blk_start, job_ready, busy);
        end
        checks++;
        if ({blk_seed, blk_poly, blk_mask_i, blk_mask_o, blk_limit} !== {cur_seed, cur_poly, cur_mi, cur_mo, cur_limit}
            || blk_keys !== cur_keys) begin
            errors++;
            $display("FAIL %s_config: got seed=%h limit=%h want seed=%h limit=%h", tag, blk_seed, blk_limit, cur_seed, cur_limit);
        end
    endtask

    // From the LOAD negedge: complete the job after run_len cycles, apply bp
    // cycles of result backpressure, then check the handshake and CLEAR.
    task automatic finish_job(input logic [IW-1:0] id, input logic [63:0] cnt, input int run_len,
                              input int bp, input string tag, input int s0, input int r0);
        logic early;
        logic stable;
        early = 1'b0;
        stable = 1'b1;
        repeat (run_len) begin
            @(negedge clk);
            if (res_valid) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL %s_early_result: got res_valid=1 want 0 before blk_done", tag);
        end
        blk_done = 1'b1; blk_counter = cnt;
        @(negedge clk);
        blk_done = 1'b0; blk_counter = {$urandom, $urandom};
        checks++;
        if (res_valid !== 1'b1 || res_id !== id || res_count !== cnt || res_timeout !== 1'b0 || job_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: got v=%b id=%h cnt=%h to=%b rdy=%b want v=1 id=%h cnt=%h to=0 rdy=0",
                     tag, res_valid, res_id, res_count, res_timeout, job_ready, id, cnt);
        end
        if (bp > 0) begin
            res_ready = 1'b0;
            repeat (bp) begin
                @(negedge clk);
                if (res_valid !== 1'b1 || res_id !== id || res_count !== cnt || job_ready !== 1'b0) stable = 1'b0;
            end
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL %s_backpressure: got unstable result over %0d cycles want stable", tag, bp);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_jobs = exp_jobs + 32'd1;
        checks++;
        if (res_valid !== 1'b0 || blk_restart !== 1'b1 || job_ready !== 1'b0 || jobs_done !== exp_jobs) begin
            errors++;
            $display("FAIL %s_clear: got v=%b restart=%b rdy=%b jobs=%h want 0 1 0 %h",
                     tag, res_valid, blk_restart, job_ready, jobs_done, exp_jobs);
        end
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || start_cnt - s0 != 1 || restart_cnt - r0 != 1) begin
            errors++;
            $display("FAIL %s_idle: got rdy=%b busy=%b starts=%0d restarts=%0d want 1 0 1 1",
                     tag, job_ready, busy, start_cnt - s0, restart_cnt - r0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || blk_start !== 1'b0 || blk_restart !== 1'b0
            || res_valid !== 1'b0 || res_timeout !== 1'b0 || res_id !== '0 || res_count !== '0 || jobs_done !== '0) begin
            errors++;
            $display("FAIL %s_outputs: got rdy=%b busy=%b st=%b rs=%b v=%b to=%b id=%h cnt=%h jobs=%h want rdy=1 rest 0",
                     tag, job_ready, busy, blk_start, blk_restart, res_valid, res_timeout, res_id, res_count, jobs_done);
        end
        checks++;
        if ({blk_seed, blk_poly, blk_mask_i, blk_mask_o, blk_limit} !== '0 || blk_keys !== '0) begin
            errors++;
            $display("FAIL %s_config: got seed=%h limit=%h want 0", tag, blk_seed, blk_limit);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("reset");
    endtask

    task automatic test_spurious_done;
        blk_done = 1'b1; blk_counter = 64'hDEAD;
        repeat (3) @(negedge clk);
        blk_done = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_done_ignored: got v=%b busy=%b rdy=%b want 0 0 1", res_valid, busy, job_ready);
        end
    endtask

    task automatic test_basic;
        int s0, r0;
        s0 = start_cnt; r0 = restart_cnt;
        send_job(8'h5A, 64'd16, "basic");
        finish_job(8'h5A, 64'h9, 30, 0, "basic", s0, r0);
    endtask

    task automatic test_backpressure;
        int s0, r0;
        s0 = start_cnt; r0 = restart_cnt;
        send_job(8'hC3, 64'd100, "bp");
        finish_job(8'hC3, 64'h1234_5678_9ABC_DEF0, 7, 10, "bp", s0, r0);
    endtask

    task automatic test_abort_with_done;
        int r0;
        r0 = restart_cnt;
        send_job(8'h11, 64'd50, "abort_run");
        repeat (5) @(negedge clk);
        abort = 1'b1; blk_done = 1'b1; blk_counter = 64'h77;
        @(negedge clk);
        abort = 1'b0; blk_done = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || blk_restart !== 1'b1 || job_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_run_clear: got v=%b restart=%b rdy=%b want 0 1 0", res_valid, blk_restart, job_ready);
        end
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || res_valid !== 1'b0 || jobs_done !== exp_jobs || restart_cnt - r0 != 1) begin
            errors++;
            $display("FAIL abort_run_idle: got rdy=%b v=%b jobs=%h restarts=%0d want 1 0 %h 1",
                     job_ready, res_valid, jobs_done, restart_cnt - r0, exp_jobs);
        end
    endtask

    task automatic test_abort_in_load;
        send_job(8'h22, 64'd50, "abort_load");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (blk_restart !== 1'b1 || blk_start !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_load_clear: got restart=%b start=%b v=%b want 1 0 0", blk_restart, blk_start, res_valid);
        end
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || jobs_done !== exp_jobs) begin
            errors++;
            $display("FAIL abort_load_idle: got rdy=%b jobs=%h want 1 %h", job_ready, jobs_done, exp_jobs);
        end
    endtask

    task automatic test_reset_mid_run;
        int s0, r0;
        send_job(8'h33, 64'd50, "rst_run");
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_jobs = '0;
        check_reset_state("rst_run");
        s0 = start_cnt; r0 = restart_cnt;
        send_job(8'h44, 64'd20, "after_rst");
        finish_job(8'h44, 64'hABCD, 5, 2, "after_rst", s0, r0);
    endtask

    task automatic test_jobs_done_wrap;
        int s0, r0;
        force dut.jobs_done = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.jobs_done;
        exp_jobs = 32'hFFFF_FFFF;
        s0 = start_cnt; r0 = restart_cnt;
        send_job(8'h55, 64'd8, "wrap");
        finish_job(8'h55, 64'h1, 3, 0, "wrap", s0, r0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 10; k++) begin
            int s0, r0, run_len, bp;
            logic [IW-1:0] id;
            logic [63:0]   cnt;
            id      = IW'($urandom);
            cnt     = {$urandom, $urandom};
            run_len = $urandom_range(1, 20);
            bp      = $urandom_range(0, 4);
            s0 = start_cnt; r0 = restart_cnt;
            send_job(id, {32'd0, $urandom}, "rand");
            finish_job(id, cnt, run_len, bp, "rand", s0, r0);
        end
    endtask

    task automatic test_watchdog;
`ifdef WATCHDOG_EN
        int n;
        n = 0;
        send_job(8'h66, 64'd4, "wdog");
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        // n counts cycles after LOAD; the last one is the first REPORT cycle.
        checks++;
        if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_id !== 8'h66 || n - 1 != 68) begin
            errors++;
            $display("FAIL wdog_fire: got v=%b to=%b id=%h run_cycles=%0d want 1 1 66 68",
                     res_valid, res_timeout, res_id, n - 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_jobs = exp_jobs + 32'd1;
        checks++;
        if (res_timeout !== 1'b0 || res_valid !== 1'b0 || jobs_done !== exp_jobs) begin
            errors++;
            $display("FAIL wdog_clear: got to=%b v=%b jobs=%h want 0 0 %h", res_timeout, res_valid, jobs_done, exp_jobs);
        end
        @(negedge clk);
`else
        logic held;
        held = 1'b1;
        send_job(8'h66, 64'd4, "nowdog");
        repeat (150) begin
            @(negedge clk);
            if (busy !== 1'b1 || res_valid !== 1'b0 || res_timeout !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL nowdog_hang: got result or idle want busy=1 res_valid=0 for 150 cycles");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || jobs_done !== exp_jobs) begin
            errors++;
            $display("FAIL nowdog_abort: got rdy=%b jobs=%h want 1 %h", job_ready, jobs_done, exp_jobs);
        end
`endif
    endtask

    task automatic test_pulse_exclusive;
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL start_restart_overlap: got %0d cycles want 0", overlap_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_spurious_done();
        test_basic();
        test_backpressure();
        test_abort_with_done();
        test_abort_in_load();
        test_reset_mid_run();
        test_jobs_done_wrap();
        test_random();
        test_watchdog();
        test_pulse_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
